sprite_index_gen: RTL

- Producer side of the per-pixel sprite interface consumed by the colour mapper: emits one sprite's hit flag plus 4-bit palette index for the pixel being scanned.
- Holds frame-synchronised (double-buffered) position/visibility, tests DrawX/DrawY against the sprite box, drives a synchronous sprite ROM, returns a registered, latency-fixed result.
- One instance per sprite (player, hook, gold, stone, explosion) between game logic and colour mapper.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_pos_shadow.sv | 55 +++++
 rtl/sprite_index_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the per-pixel sprite producers that feed
// the colour mapper.
//   coord_t         : 10-bit screen coordinate
//   pal_idx_t       : 4-bit palette index
//   TRANSPARENT_IDX : palette index the mapper treats as "no colour"
//   SPRITE_LATENCY  : pixel strobes from DrawX/DrawY to sprite outputs
//   SCREEN_W/H      : visible raster size
//   spr_state_e     : sequencing state of a sprite producer
// ---------------------------------------------------------------------------
package sprite_pkg;

   typedef logic [9:0] coord_t;
   typedef logic [3:0] pal_idx_t;

   localparam pal_idx_t TRANSPARENT_IDX = 4'd0;
   localparam int       SPRITE_LATENCY  = 2;
   localparam int       SCREEN_W        = 640;
   localparam int       SCREEN_H        = 480;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      RUN        = 1'b1
   } spr_state_e;

endpackage

// File: rtl/sprite_pos_shadow.sv
// ---------------------------------------------------------------------------
// sprite_pos_shadow
// Pending/active register pair for frame-synchronous parameter updates.
// wr loads pending; sync copies pending into active. When wr and sync land
// in the same clock, both registers take the incoming value so a write made
// exactly on the frame boundary is not lost for a whole frame.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset, clears both registers
//   wr       : load strobe for pending
//   sync     : frame boundary strobe, pending -> active
//   data_in  : new value
//   pending  : value waiting for the next frame boundary
//   active   : value in use for the current frame
// ---------------------------------------------------------------------------
module sprite_pos_shadow #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr,
   input  logic              sync,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] pending,
   output logic [DATA_W-1:0] active
);

   logic [DATA_W-1:0] pending_q, pending_d;
   logic [DATA_W-1:0] active_q,  active_d;

   always_comb begin
      pending_d = pending_q;
      active_d  = active_q;
      if (wr) begin
         pending_d = data_in;
      end
      if (sync) begin
         active_d = wr ? data_in : pending_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= '0;
         active_q  <= '0;
      end else begin
         pending_q <= pending_d;
         active_q  <= active_d;
      end
   end

   assign pending = pending_q;
   assign active  = active_q;

endmodule

// File: rtl/sprite_index_gen.sv
// ---------------------------------------------------------------------------
// sprite_index_gen
// Per-sprite producer for the colour mapper: tests the scanned pixel against
// a frame-synchronised sprite box, addresses the synchronous sprite ROM and
// returns a registered hit flag plus palette index two pixel strobes later.
//
// Build option: define SPRITE_FLIP_EN to build the horizontal mirror.
// Without it flip_in is ignored and no flip register exists.
//
// Ports:
//   clk, reset_n       : system clock, asynchronous active-low reset
//   pixel_ce           : one-clock strobe per pixel, pipeline advances on it
//   frame_start        : pulse with the pixel_ce of (0,0), swaps buffers
//   DrawX, DrawY       : current scan position
//   pos_x_in, pos_y_in : new sprite top-left corner
//   visible_in         : new visibility
//   flip_in            : new horizontal mirror request
//   pos_wr             : loads the pending position registers
//   rom_addr           : sprite ROM address, row*SPR_W+col
//   rom_data           : ROM palette index, valid one clock after rom_addr
//   is_sprite          : pixel is inside the visible sprite box
//   sprite_index       : palette index for the pixel, 0 = transparent
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_FRAME | after reset; outputs forced to 0 until first frame_start
// RUN        | normal scan; stays here until reset
// ---------------------------------------------------------------------------
module sprite_index_gen
   import sprite_pkg::*;
#(
   parameter int SPR_W  = 32,
   parameter int SPR_H  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pixel_ce,
   input  logic              frame_start,
   input  coord_t            DrawX,
   input  coord_t            DrawY,
   input  coord_t            pos_x_in,
   input  coord_t            pos_y_in,
   input  logic              visible_in,
   input  logic              flip_in,
   input  logic              pos_wr,
   output logic [ADDR_W-1:0] rom_addr,
   input  pal_idx_t          rom_data,
   output logic              is_sprite,
   output pal_idx_t          sprite_index
);

   localparam int XW = $clog2(SPR_W);
   localparam int YW = $clog2(SPR_H);

   // -----------------------------------------------------------------------
   // Frame-synchronised position / visibility (/ flip)
   // -----------------------------------------------------------------------
   coord_t act_x, act_y;
   logic   act_vis;
   logic   act_flip;

`ifdef SPRITE_FLIP_EN
   localparam int SH_W = 22;
   logic [SH_W-1:0] sh_in, sh_pend, sh_act;

   assign sh_in = {pos_x_in, pos_y_in, visible_in, flip_in};
   assign {act_x, act_y, act_vis, act_flip} = sh_act;
`else
   localparam int SH_W = 21;
   logic [SH_W-1:0] sh_in, sh_pend, sh_act;
   logic            unused_flip_in;

   assign unused_flip_in = flip_in;
   assign sh_in          = {pos_x_in, pos_y_in, visible_in};
   assign {act_x, act_y, act_vis} = sh_act;
   assign act_flip       = 1'b0;
`endif

   logic unused_pend;
   assign unused_pend = ^sh_pend;

   sprite_pos_shadow #(
      .DATA_W (SH_W)
   ) u_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (pos_wr),
      .sync    (frame_start),
      .data_in (sh_in),
      .pending (sh_pend),
      .active  (sh_act)
   );

   // -----------------------------------------------------------------------
   // Sequencing FSM
   // -----------------------------------------------------------------------
   spr_state_e state_q, state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_FRAME: if (frame_start) state_d = RUN;
         RUN:        state_d = RUN;
         default:    state_d = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= WAIT_FRAME;
      else          state_q <= state_d;
   end

   // -----------------------------------------------------------------------
   // Stage 1: box test and ROM address
   // The extra MSB of dx/dy is the borrow, so a pixel left of / above the
   // sprite shows up as a huge value and fails the size compare as well.
   // -----------------------------------------------------------------------
   logic [10:0]       dx, dy;
   logic              hit;
   logic [XW-1:0]     col_raw, col;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              hit1_q, hit1_d;

   assign dx = {1'b0, DrawX} - {1'b0, act_x};
   assign dy = {1'b0, DrawY} - {1'b0, act_y};

   assign hit = act_vis & ~dx[10] & ~dy[10]
              & (dx < 11'(SPR_W)) & (dy < 11'(SPR_H));

   assign col_raw = dx[XW-1:0];
   assign col     = act_flip ? (XW'(SPR_W - 1) - col_raw) : col_raw;

   always_comb begin
      rom_addr_d = rom_addr_q;
      hit1_d     = hit1_q;
      if (pixel_ce) begin
         hit1_d = hit;
         if (hit) begin
            rom_addr_d = ADDR_W'({dy[YW-1:0], col});
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_addr_q <= '0;
         hit1_q     <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         hit1_q     <= hit1_d;
      end
   end

   // -----------------------------------------------------------------------
   // Stage 2: ROM data has had at least one clock since the address strobe
   // -----------------------------------------------------------------------
   logic     is_spr_q, is_spr_d;
   pal_idx_t idx_q, idx_d;
   logic     out_hit;

   assign out_hit = hit1_q & (state_q == RUN);

   always_comb begin
      is_spr_d = is_spr_q;
      idx_d    = idx_q;
      if (pixel_ce) begin
         is_spr_d = out_hit;
         idx_d    = out_hit ? rom_data : TRANSPARENT_IDX;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_spr_q <= 1'b0;
         idx_q    <= TRANSPARENT_IDX;
      end else begin
         is_spr_q <= is_spr_d;
         idx_q    <= idx_d;
      end
   end

   assign rom_addr     = rom_addr_q;
   assign is_sprite    = is_spr_q;
   assign sprite_index = idx_q;

endmodule
